// File: rtl/weapons_bank_if.sv
// Bus bundle for weapons_bank: ship mode, per-channel fire/load/capacity
// strobes with their shared operands, and the per-channel status outputs.
// The master side is whoever drives the requests; the slave side is the bank.
interface weapons_bank_if #(
  parameter int N_CH = 4,
  parameter int AW   = 9,
  parameter int CW   = 4
);
  logic [3:0]         mode;
  logic [N_CH-1:0]    fire;
  logic [N_CH-1:0]    load;
  logic [AW-1:0]      load_val;
  logic [N_CH-1:0]    max_load;
  logic [AW-1:0]      max_val;
  logic [AW-1:0]      rate;
  logic [CW-1:0]      cooldown;
  logic [N_CH*AW-1:0] ammo_out;
  logic [N_CH-1:0]    ready;
  logic [N_CH-1:0]    shot;
  logic [N_CH-1:0]    error;

  modport master (
    output mode, fire, load, load_val, max_load, max_val, rate, cooldown,
    input  ammo_out, ready, shot, error
  );

  modport slave (
    input  mode, fire, load, load_val, max_load, max_val, rate, cooldown,
    output ammo_out, ready, shot, error
  );
endinterface

// File: rtl/weapons_bank.sv
// weapons_bank: N_CH independent weapon channels, each tracking ammo, a
// capacity limit and a post-shot cooldown. Accepted shots and rejected
// requests are reported as registered one-cycle pulses.
// Optional feature: define WEAPONS_AUTORELOAD_EN to add a RELOAD state that
// refills an empty idle channel by one round per cycle up to its capacity.
module weapons_bank #(
  parameter int          N_CH        = 4,
  parameter int          AW          = 9,
  parameter int          CW          = 4,
  parameter logic [3:0]  ATTACK_MODE = 4'b0010
) (
  input  logic           clk,
  input  logic           rst,
  weapons_bank_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COOL   = 2'd1;
`ifdef WEAPONS_AUTORELOAD_EN
  localparam logic [1:0] ST_RELOAD = 2'd2;
`endif

  logic [AW-1:0] ammo_q  [N_CH];
  logic [AW-1:0] ammo_d  [N_CH];
  logic [AW-1:0] max_q   [N_CH];
  logic [AW-1:0] max_d   [N_CH];
  logic [1:0]    state_q [N_CH];
  logic [1:0]    state_d [N_CH];
  logic [CW-1:0] cnt_q   [N_CH];
  logic [CW-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0] shot_q, shot_d;
  logic [N_CH-1:0] error_q, error_d;
  logic [N_CH-1:0] accept;
  logic [N_CH-1:0] reject;
  logic            mode_ok;

  // Saturating subtract: never wraps below zero.
  function automatic logic [AW-1:0] sat_sub(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  // Clamp a value to a ceiling.
  function automatic logic [AW-1:0] clamp_to(input logic [AW-1:0] v,
                                             input logic [AW-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign mode_ok = (bus.mode == ATTACK_MODE);

  // Per-channel next-state: fire arbitration, cooldown, load/capacity updates.
  always_comb begin
    accept  = '0;
    reject  = '0;
    shot_d  = '0;
    error_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      ammo_d[i]  = ammo_q[i];
      max_d[i]   = max_q[i];
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];

      accept[i] = bus.fire[i] && mode_ok && !bus.load[i] &&
                  (state_q[i] == ST_IDLE) && (ammo_q[i] != '0);
      // A cooling channel with a valid request is simply ignored; only a bad
      // mode, a colliding load or an empty idle channel is flagged.
      reject[i] = bus.fire[i] && (!mode_ok || bus.load[i] ||
                  ((state_q[i] == ST_IDLE) && (ammo_q[i] == '0))
`ifdef WEAPONS_AUTORELOAD_EN
                  || (state_q[i] == ST_RELOAD)
`endif
                  );
      shot_d[i]  = accept[i];
      error_d[i] = reject[i];

      // Capacity update lands first so loads and refills clamp to the new value.
      if (bus.max_load[i]) max_d[i] = bus.max_val;

      case (state_q[i])
        ST_IDLE: begin
          if (accept[i]) begin
            ammo_d[i] = sat_sub(ammo_q[i], bus.rate);
            if (bus.cooldown != '0) begin
              state_d[i] = ST_COOL;
              cnt_d[i]   = bus.cooldown;
            end
          end
`ifdef WEAPONS_AUTORELOAD_EN
          else if ((ammo_q[i] == '0) && !bus.load[i] && !bus.max_load[i]) begin
            state_d[i] = ST_RELOAD;
          end
`endif
        end
        ST_COOL: begin
          cnt_d[i] = cnt_q[i] - CW'(1);
          if (cnt_q[i] <= CW'(1)) state_d[i] = ST_IDLE;
        end
`ifdef WEAPONS_AUTORELOAD_EN
        ST_RELOAD: begin
          ammo_d[i] = (ammo_q[i] >= max_d[i]) ? max_d[i] : ammo_q[i] + AW'(1);
          if (ammo_d[i] == max_d[i]) state_d[i] = ST_IDLE;
        end
`endif
        default: state_d[i] = ST_IDLE;
      endcase

      if (bus.load[i]) begin
        ammo_d[i] = clamp_to(bus.load_val, max_d[i]);
`ifdef WEAPONS_AUTORELOAD_EN
        if (state_q[i] == ST_RELOAD) state_d[i] = ST_IDLE;
`endif
      end else if (bus.max_load[i]) begin
        ammo_d[i] = clamp_to(ammo_d[i], bus.max_val);
      end
    end
  end

  // State registers; reset empties every channel and restores full capacity.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        ammo_q[i]  <= '0;
        max_q[i]   <= '1;
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      shot_q  <= '0;
      error_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        ammo_q[i]  <= ammo_d[i];
        max_q[i]   <= max_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      shot_q  <= shot_d;
      error_q <= error_d;
    end
  end

  // Output packing and readiness status.
  always_comb begin
    bus.ammo_out = '0;
    bus.ready    = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.ammo_out[i*AW +: AW] = ammo_q[i];
      bus.ready[i] = (state_q[i] == ST_IDLE) && (ammo_q[i] != '0);
    end
    bus.shot  = shot_q;
    bus.error = error_q;
  end

endmodule
